// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: accepts a WIDTH-bit word over valid/ready
// and emits it one bit per clock on y, framed by y_valid/y_last, gapless back-to-back.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             y,
  output logic             y_valid,
  output logic             y_last,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [WIDTH-1:0] w_shifted;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_in_shift;
  logic             w_at_last;
  logic             w_accept;
  logic             w_head;

  assign w_in_shift = (r_state == SHIFT);
  assign w_at_last  = w_in_shift && (r_cnt == LAST_IDX);

  // Ready is decoded from registered state only, so a source may hold
  // load_valid high and the handshake can never form a combinational loop.
  assign load_ready = !w_in_shift || w_at_last;
  assign w_accept   = load_valid && load_ready;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_head    = r_shift[WIDTH-1];
      assign w_shifted = {r_shift[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign w_head    = r_shift[0];
      assign w_shifted = {1'b0, r_shift[WIDTH-1:1]};
    end
  endgenerate

  // NOTE: every next-state signal gets its default before the case; without
  // it a path that skips an assignment would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = SHIFT;
          w_shift_nxt = load_data;
          w_cnt_nxt   = '0;
        end
      end
      SHIFT: begin
        if (w_at_last) begin
          if (w_accept) begin
            w_shift_nxt = load_data;
          end else begin
            w_state_nxt = IDLE;
            w_shift_nxt = w_shifted;
          end
          w_cnt_nxt = '0;
        end else begin
          w_shift_nxt = w_shifted;
          w_cnt_nxt   = r_cnt + CW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign y       = w_in_shift && w_head;
  assign y_valid = w_in_shift;
  assign y_last  = w_at_last;
  assign busy    = w_in_shift;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: three instances (8-bit MSB-first,
// 8-bit LSB-first, 2-bit MSB-first) checked every cycle against expected bit queues.
module tb_piso_serializer;

  logic       clk;
  logic       rst;

  logic       lv_a, rdy_a, y_a, yv_a, yl_a, busy_a;
  logic [7:0] ld_a;
  logic       lv_b, rdy_b, y_b, yv_b, yl_b, busy_b;
  logic [7:0] ld_b;
  logic       lv_c, rdy_c, y_c, yv_c, yl_c, busy_c;
  logic [1:0] ld_c;

  int n_total = 0;
  int n_pass  = 0;

  // Expected frame bits per instance, {last, y}.
  bit [1:0] q_a[$];
  bit [1:0] q_b[$];
  bit [1:0] q_c[$];

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut_a (
    .clk(clk), .reset(rst), .load_valid(lv_a), .load_ready(rdy_a), .load_data(ld_a),
    .y(y_a), .y_valid(yv_a), .y_last(yl_a), .busy(busy_a)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut_b (
    .clk(clk), .reset(rst), .load_valid(lv_b), .load_ready(rdy_b), .load_data(ld_b),
    .y(y_b), .y_valid(yv_b), .y_last(yl_b), .busy(busy_b)
  );

  piso_serializer #(.WIDTH(2), .MSB_FIRST(1'b1)) u_dut_c (
    .clk(clk), .reset(rst), .load_valid(lv_c), .load_ready(rdy_c), .load_data(ld_c),
    .y(y_c), .y_valid(yv_c), .y_last(yl_c), .busy(busy_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int id, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, id, obs, exp);
  endtask

  function automatic int qsize(input int id);
    case (id)
      0:       return q_a.size();
      1:       return q_b.size();
      default: return q_c.size();
    endcase
  endfunction

  task automatic push_word(input int id, input logic [31:0] data);
    int w;
    bit msb;
    case (id)
      0:       begin w = 8; msb = 1'b1; end
      1:       begin w = 8; msb = 1'b0; end
      default: begin w = 2; msb = 1'b1; end
    endcase
    for (int i = 0; i < w; i++) begin
      bit [1:0] e;
      e = {(i == w - 1), data[msb ? (w - 1 - i) : i]};
      case (id)
        0:       q_a.push_back(e);
        1:       q_b.push_back(e);
        default: q_c.push_back(e);
      endcase
    end
  endtask

  task automatic set_load(input int id, input bit v, input logic [31:0] d);
    case (id)
      0:       begin lv_a = v; ld_a = d[7:0]; end
      1:       begin lv_b = v; ld_b = d[7:0]; end
      default: begin lv_c = v; ld_c = d[1:0]; end
    endcase
  endtask

  // Compare one instance's outputs for the current cycle against its queue.
  task automatic step(input int id);
    logic o_y, o_v, o_l, o_b, o_r;
    bit [1:0] e;
    bit ev;
    case (id)
      0:       begin o_y = y_a; o_v = yv_a; o_l = yl_a; o_b = busy_a; o_r = rdy_a; end
      1:       begin o_y = y_b; o_v = yv_b; o_l = yl_b; o_b = busy_b; o_r = rdy_b; end
      default: begin o_y = y_c; o_v = yv_c; o_l = yl_c; o_b = busy_c; o_r = rdy_c; end
    endcase
    ev = (qsize(id) > 0);
    e  = 2'b00;
    if (ev) begin
      case (id)
        0:       e = q_a.pop_front();
        1:       e = q_b.pop_front();
        default: e = q_c.pop_front();
      endcase
    end
    check("y_valid",    id, o_v, ev);
    check("busy",       id, o_b, ev);
    check("y",          id, o_y, e[0]);
    check("y_last",     id, o_l, e[1]);
    check("load_ready", id, o_r, (qsize(id) == 0));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (rst) begin
      q_a.delete();
      q_b.delete();
      q_c.delete();
    end
    step(0);
    step(1);
    step(2);
  endtask

  // Hold load_valid until the model says the block is ready, then accept d.
  task automatic send(input int id, input logic [31:0] d);
    for (int k = 0; k < 64; k++) begin
      if (qsize(id) == 0) begin
        set_load(id, 1'b1, d);
        push_word(id, d);
        cyc();
        return;
      end
      cyc();
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && (qsize(0) + qsize(1) + qsize(2)) > 0; k++) cyc();
    cyc();
    cyc();
  endtask

  initial begin
    rst = 1'b1;
    set_load(0, 1'b0, 0);
    set_load(1, 1'b0, 0);
    set_load(2, 1'b0, 0);
    cyc();
    cyc();
    rst = 1'b0;
    cyc();

    // Single word, data bus toggled afterwards without valid.
    send(0, 32'hA5);
    set_load(0, 1'b0, 32'h5A);
    drain();

    // Back-to-back: A5 held valid, 3C accepted on the y_last cycle.
    send(0, 32'hA5);
    send(0, 32'h3C);
    set_load(0, 1'b0, 0);
    drain();

    // Load pulse while not ready is ignored.
    send(0, 32'hFF);
    set_load(0, 1'b0, 32'hFF);
    cyc();
    cyc();
    set_load(0, 1'b1, 32'h00);
    cyc();
    set_load(0, 1'b0, 32'h00);
    drain();

    // Reset during bit 4, then a fresh word.
    send(0, 32'hA5);
    set_load(0, 1'b0, 0);
    cyc();
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    send(0, 32'h3C);
    set_load(0, 1'b0, 0);
    drain();

    // LSB-first.
    send(1, 32'h01);
    set_load(1, 1'b0, 0);
    drain();
    send(1, 32'h80);
    set_load(1, 1'b0, 0);
    drain();

    // Minimum width, back-to-back.
    send(2, 32'h2);
    send(2, 32'h1);
    set_load(2, 1'b0, 0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in/serial-out transmitter: the source end of the single-bit serial path that the shift-register pipeline consumes on input `a`.
- Accepts a WIDTH-bit word through a valid/ready handshake.
- Emits the word one bit per clock on `y`, with `y_valid` and `y_last` framing.
- Supports gapless back-to-back words, so downstream shift logic can be driven from RTL instead of hand-written stimulus.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- load_valid  input  1  load_data is valid.
- load_ready  output  1  block can accept a word this cycle.
- load_data  input  WIDTH  word to serialize.
- y  output  1  serial data bit.
- y_valid  output  1  y carries a frame bit this cycle.
- y_last  output  1  y is the final bit of the current word.
- busy  output  1  a word is in flight (state SHIFT).

Behaviour:
- Reset (reset=1 at a clk edge) applies on that edge regardless of state:
  - state=IDLE; shift register, bit counter, y, y_valid, y_last all 0.
  - Any frame in progress is abandoned; no partial bits after the edge.
- States: IDLE, SHIFT.
- Handshake:
  - Accept occurs when load_valid && load_ready at a clk edge.
  - load_data is sampled only on accept; changes to load_data at other times have no effect.
- load_ready is combinational from registered state only (never depends on load_valid):
  - 1 in IDLE.
  - 1 in SHIFT when bit counter == WIDTH-1 (last bit on the wire).
  - 0 otherwise.
- IDLE:
  - y=0, y_valid=0, y_last=0, busy=0.
  - On accept: load shifter, counter=0, go SHIFT.
- SHIFT:
  - y_valid=1; y = current head bit of the shifter (MSB if MSB_FIRST, else LSB).
  - Each edge: shift by one, counter+1.
  - y_last=1 when counter == WIDTH-1.
- Latency: first bit appears on y in the cycle after the accept edge. A word occupies exactly WIDTH consecutive y_valid cycles.
- End of word (counter == WIDTH-1):
  - With accept on that edge: reload, counter=0, stay in SHIFT. The next word's first bit follows with no gap.
  - Without accept: go IDLE; y_valid drops on the next cycle.
- load_valid asserted while load_ready=0 is ignored, not queued. The source holds it until accepted.
- y, y_valid, y_last, busy are registered or decoded from registers only; no combinational path from any input to any of them.
- Counter width is clog2(WIDTH) bits; it never exceeds WIDTH-1.

Test Plan:
- Single word: reset 2 cycles, WIDTH=8, MSB_FIRST=1, load 8'hA5 at cycle 3 -> y = 1,0,1,0,0,1,0,1 on cycles 4..11; y_valid high exactly on 4..11; y_last only on 11; load_ready 0 on 4..10 and 1 on 11; IDLE at 12.
- Back-to-back: hold load_valid with 8'hA5, then 8'h3C accepted on the y_last cycle -> 16 contiguous y_valid cycles, y = 10100101 00111100; y_last on bits 8 and 16.
- LSB-first: MSB_FIRST=0, load 8'h01 -> y = 1,0,0,0,0,0,0,0; load 8'h80 -> y = 0,0,0,0,0,0,0,1.
- Ignored load: during bit 3 of 8'hFF, pulse load_valid=1 with 8'h00 for 1 cycle -> no effect; y stays all 1s for 8 bits; returns to IDLE; no second word.
- Reset mid-frame: assert reset during bit 4 of 8'hA5 -> on the next cycle y=0, y_valid=0, y_last=0, busy=0, load_ready=1. A fresh 8'h3C load then serializes fully and correctly.
- Width sweep: WIDTH=2 with 2'b10, 2'b01 back-to-back -> y = 1,0,0,1 over 4 contiguous valid cycles; y_last on cycles 2 and 4.
